// File: rtl/data_writer.sv
// Receive-side frame writer: parses 16 channel records (header + data) from a valid/ready stream into four bank RAMs.
// Optional trailer checksum check is enabled with `define DATA_WRITER_CHKSUM_EN.
module data_writer #(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_in_data,
    input  logic              i_in_sof,
    input  logic              i_in_vld,
    output logic              o_in_rdy,
    input  logic              i_wr_rdy,
    output logic [1:0]        o_wr_vchn,
    output logic [3:0]        o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_len_we,
    output logic [1:0]        o_len_bank,
    output logic [1:0]        o_len_vchn,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_complite,
    output logic              o_busy,
    output logic [1:0]        o_err,
    input  logic              i_err_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
`ifdef DATA_WRITER_CHKSUM_EN
        S_TRL,
`endif
        S_DONE,
        S_RESYNC
    } state_t;

    state_t             state;
    logic [3:0]         ch;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len;
`ifdef DATA_WRITER_CHKSUM_EN
    logic [31:0]        sum;
`endif

    logic               accept;
    logic               take_hdr;
    logic               sof_err;
    logic               hdr_bad;
    logic               data_beat;
    logic               last_word;
    logic               advance;
    logic [3:0]         hdr_ch;
    logic [3:0]         adv_ch;
    logic [LEN_W-1:0]   hdr_len;

    assign o_in_rdy = i_wr_rdy & (state != S_DONE);
    assign accept   = i_in_vld & o_in_rdy;

    // A sof beat is always a channel-0 header, whatever state it lands in.
    always_comb begin
        take_hdr = 1'b0;
        sof_err  = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE, S_RESYNC: take_hdr = i_in_sof;
                S_HDR: begin
                    take_hdr = 1'b1;
                    sof_err  = i_in_sof & (ch != 4'd0);
                end
                S_DONE: take_hdr = 1'b0;
                default: begin
                    take_hdr = i_in_sof;
                    sof_err  = i_in_sof;
                end
            endcase
        end
        hdr_ch    = i_in_sof ? 4'd0 : ch;
        hdr_len   = i_in_data[LEN_W-1:0];
        hdr_bad   = (i_in_data[31:LEN_W] != '0) ||
                    ({{(32-LEN_W){1'b0}}, hdr_len} > 32'(MAX_LEN));
        data_beat = accept & (state == S_DATA) & ~i_in_sof;
        last_word = (cnt == len - LEN_W'(1));
        advance   = (take_hdr & ~hdr_bad & (hdr_len == '0)) | (data_beat & last_word);
        adv_ch    = take_hdr ? hdr_ch : ch;
    end

    always_comb begin
        o_busy = (state == S_HDR) || (state == S_DATA);
`ifdef DATA_WRITER_CHKSUM_EN
        if (state == S_TRL) o_busy = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ch         <= '0;
            cnt        <= '0;
            len        <= '0;
`ifdef DATA_WRITER_CHKSUM_EN
            sum        <= '0;
`endif
            o_wr_vchn  <= '0;
            o_wr_en    <= '0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_len_we   <= 1'b0;
            o_len_bank <= '0;
            o_len_vchn <= '0;
            o_len      <= '0;
            o_complite <= 1'b0;
            o_err      <= '0;
        end else begin
            o_wr_en    <= '0;
            o_len_we   <= 1'b0;
            o_complite <= 1'b0;
            // Set wins over clear: the set assignments below come later.
            if (i_err_clr) o_err <= '0;
            if (sof_err)   o_err[0] <= 1'b1;

            if (take_hdr) begin
`ifdef DATA_WRITER_CHKSUM_EN
                sum <= i_in_sof ? i_in_data : sum + i_in_data;
`endif
                if (hdr_bad) begin
                    o_err[0] <= 1'b1;
                    state    <= S_RESYNC;
                end else begin
                    o_len_we   <= 1'b1;
                    o_len_bank <= hdr_ch[3:2];
                    o_len_vchn <= hdr_ch[1:0];
                    o_len      <= hdr_len;
                    len        <= hdr_len;
                    cnt        <= '0;
                    ch         <= hdr_ch;
                    if (hdr_len != '0) state <= S_DATA;
                end
            end else if (data_beat) begin
`ifdef DATA_WRITER_CHKSUM_EN
                sum <= sum + i_in_data;
`endif
                o_wr_en   <= 4'b0001 << ch[3:2];
                o_wr_vchn <= ch[1:0];
                o_wr_addr <= ADDR_W'(cnt);
                o_wr_data <= i_in_data;
                cnt       <= cnt + LEN_W'(1);
            end
`ifdef DATA_WRITER_CHKSUM_EN
            else if (accept && (state == S_TRL)) begin
                if (i_in_data != sum) o_err[1] <= 1'b1;
                state      <= S_DONE;
                o_complite <= 1'b1;
            end
`endif
            else if (state == S_DONE) begin
                state <= S_IDLE;
                ch    <= '0;
            end

            if (advance) begin
                if (adv_ch != 4'hF) begin
                    ch    <= adv_ch + 4'd1;
                    state <= S_HDR;
                end else begin
`ifdef DATA_WRITER_CHKSUM_EN
                    state      <= S_TRL;
`else
                    state      <= S_DONE;
                    o_complite <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_data_writer.sv
// Randomized bench for data_writer: frames are described as per-channel lengths and expanded into
// expected length/write/complete events per beat; compiled with or without DATA_WRITER_CHKSUM_EN.
module tb_data_writer;

    localparam int ADDR_W  = 10;
    localparam int LEN_W   = 8;
    localparam int MAX_LEN = 255;
`ifdef DATA_WRITER_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [31:0]       i_in_data;
    logic              i_in_sof;
    logic              i_in_vld;
    logic              o_in_rdy;
    logic              i_wr_rdy;
    logic [1:0]        o_wr_vchn;
    logic [3:0]        o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [31:0]       o_wr_data;
    logic              o_len_we;
    logic [1:0]        o_len_bank;
    logic [1:0]        o_len_vchn;
    logic [LEN_W-1:0]  o_len;
    logic              o_complite;
    logic              o_busy;
    logic [1:0]        o_err;
    logic              i_err_clr;

    data_writer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_data(i_in_data), .i_in_sof(i_in_sof), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
        .i_wr_rdy(i_wr_rdy), .o_wr_vchn(o_wr_vchn), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_len_we(o_len_we), .o_len_bank(o_len_bank),
        .o_len_vchn(o_len_vchn), .o_len(o_len), .o_complite(o_complite), .o_busy(o_busy),
        .o_err(o_err), .i_err_clr(i_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = no output event, 1 = bank write, 2 = length strobe (idx holds the length)
    typedef struct {
        logic [31:0] word;
        bit          sof;
        int          kind;
        logic [3:0]  ch;
        int          idx;
        bit          done;
    } beat_t;

    beat_t beat_q[$];
    int    lens[16];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_beat(input logic [31:0] w, input bit sof, input int kind,
                            input logic [3:0] ch, input int idx, input bit done);
        beat_t b;
        b.word = w; b.sof = sof; b.kind = kind; b.ch = ch; b.idx = idx; b.done = done;
        beat_q.push_back(b);
    endtask

    task automatic fill_lens(input int maxl);
        for (int c = 0; c < 16; c++) lens[c] = $urandom_range(0, maxl);
    endtask

    // Expand a frame; stop_ch/stop_word cut it short (bad header or mid-record abort).
    task automatic push_frame(input int l[16], input int stop_ch, input int stop_word,
                              input bit bad_hdr, input logic [31:0] trl_delta);
        logic [31:0] sum = 32'd0;
        logic [31:0] w;
        for (int c = 0; c < 16; c++) begin
            if (bad_hdr && c == stop_ch) begin
                add_beat(32'h0000_0100, c == 0, 0, 4'(c), 0, 1'b0);
                return;
            end
            w = 32'(l[c]);
            sum += w;
            add_beat(w, c == 0, 2, 4'(c), l[c], !CHK && c == 15 && l[c] == 0);
            for (int i = 0; i < l[c]; i++) begin
                if (c == stop_ch && i == stop_word) return;
                w = $urandom;
                sum += w;
                add_beat(w, 1'b0, 1, 4'(c), i, !CHK && c == 15 && i == l[c] - 1);
            end
        end
        if (CHK) add_beat(sum + trl_delta, 1'b0, 0, 4'd0, 0, 1'b1);
    endtask

    task automatic add_junk(input int n);
        for (int i = 0; i < n; i++) add_beat($urandom, 1'b0, 0, 4'd0, 0, 1'b0);
    endtask

    // Drive queued beats; every cycle check the outputs caused by the previous accepted beat.
    task automatic run_beats(input bit toggle);
        beat_t last;
        bit    have = 1'b0;
        bit    acc;
        int    cyc  = 0;
        while ((beat_q.size() != 0 || have) && cyc < 5000) begin
            @(negedge clk);
            if (have && last.kind == 1)
                check("wr", 64'({o_wr_en, o_wr_vchn, o_wr_addr, o_wr_data}),
                      64'({4'b0001 << last.ch[3:2], last.ch[1:0], 10'(last.idx), last.word}));
            else
                check("wr_idle", 64'(o_wr_en), 64'd0);
            if (have && last.kind == 2)
                check("len", 64'({o_len_we, o_len_bank, o_len_vchn, o_len}),
                      64'({1'b1, last.ch[3:2], last.ch[1:0], 8'(last.idx)}));
            else
                check("len_idle", 64'(o_len_we), 64'd0);
            check("complite", 64'(o_complite), 64'(have && last.done));
            if (have && last.kind != 0) check("busy", 64'(o_busy), 64'(!last.done));
            if (have && last.done) check("rdy_done", 64'(o_in_rdy), 64'd0);
            have = 1'b0;

            i_wr_rdy = toggle ? ~i_wr_rdy : ($urandom_range(0, 4) != 0);
            if (beat_q.size() != 0 && (toggle || $urandom_range(0, 3) != 0)) begin
                i_in_vld  = 1'b1;
                i_in_data = beat_q[0].word;
                i_in_sof  = beat_q[0].sof;
            end else begin
                i_in_vld  = 1'b0;
                i_in_data = $urandom;
                i_in_sof  = 1'($urandom);
            end
            #1 acc = i_in_vld && o_in_rdy;
            @(posedge clk);
            if (acc) begin
                last = beat_q.pop_front();
                have = 1'b1;
            end
            cyc++;
        end
        check("drain", 64'(beat_q.size()), 64'd0);
        beat_q.delete();
    endtask

    task automatic clear_err();
        @(negedge clk);
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        check("err_clr", 64'(o_err), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; i_in_vld = 1'b0; i_in_data = '0; i_in_sof = 1'b0;
        i_wr_rdy = 1'b1; i_err_clr = 1'b0;
        #2;
        check("rst_wr", 64'({o_wr_en, o_wr_vchn, o_wr_addr, o_wr_data}), 64'd0);
        check("rst_ctl", 64'({o_len_we, o_len_bank, o_len_vchn, o_len, o_complite, o_busy, o_err}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rdy_idle", 64'(o_in_rdy), 64'd1);

        // all headers zero-length
        for (int c = 0; c < 16; c++) lens[c] = 0;
        push_frame(lens, -1, 0, 1'b0, 32'd0);
        run_beats(1'b0);
        check("err_zero", 64'(o_err), 64'd0);
        check("busy_idle", 64'(o_busy), 64'd0);

        // ch 5 carries three words
        lens[5] = 3;
        push_frame(lens, -1, 0, 1'b0, 32'd0);
        run_beats(1'b0);
        check("err_ch5", 64'(o_err), 64'd0);

        // maximum length on ch 15 with ready toggling every cycle
        for (int c = 0; c < 16; c++) lens[c] = 0;
        lens[15] = 255;
        push_frame(lens, -1, 0, 1'b0, 32'd0);
        run_beats(1'b1);
        check("err_max", 64'(o_err), 64'd0);

        // oversize header on ch 2, junk ignored, next sof frame completes
        fill_lens(3);
        push_frame(lens, 2, 0, 1'b1, 32'd0);
        add_junk(3);
        run_beats(1'b0);
        check("err_bad", 64'(o_err), 64'd1);
        fill_lens(3);
        push_frame(lens, -1, 0, 1'b0, 32'd0);
        run_beats(1'b0);
        check("err_sticky", 64'(o_err), 64'd1);
        clear_err();

        // sof in the middle of ch 7 data aborts and restarts
        fill_lens(2);
        lens[7] = 4;
        push_frame(lens, 7, 2, 1'b0, 32'd0);
        fill_lens(3);
        push_frame(lens, -1, 0, 1'b0, 32'd0);
        run_beats(1'b0);
        check("err_abort", 64'(o_err), 64'd1);
        clear_err();

        // random frames separated by discarded idle-state junk
        for (int f = 0; f < 4; f++) begin
            add_junk($urandom_range(0, 2));
            fill_lens(4);
            push_frame(lens, -1, 0, 1'b0, 32'd0);
        end
        run_beats(1'b0);
        check("err_rand", 64'(o_err), 64'd0);

        // asynchronous reset in the middle of a record
        for (int c = 0; c < 16; c++) lens[c] = 1;
        lens[3] = 2;
        push_frame(lens, 3, 1, 1'b0, 32'd0);
        run_beats(1'b0);
        check("busy_mid", 64'(o_busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid", 64'({o_busy, o_complite, o_len_we, o_wr_en, o_err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_lens(2);
        push_frame(lens, -1, 0, 1'b0, 32'd0);
        run_beats(1'b0);
        check("err_after_rst", 64'(o_err), 64'd0);

`ifdef DATA_WRITER_CHKSUM_EN
        fill_lens(3);
        push_frame(lens, -1, 0, 1'b0, 32'd1);
        run_beats(1'b0);
        check("err_chksum", 64'(o_err), 64'd2);
        clear_err();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
